// File: rtl/nco_pkg.sv
// Shared constants for the quadrature NCO: dither LFSR parameters and the
// quarter-wave table generator used to build the ROM contents at elaboration.
package nco_pkg;

    localparam int          LFSR_W    = 24;
    // Galois mask for taps 24,23,22,17 (bit n-1 for tap n)
    localparam logic [23:0] LFSR_TAPS = 24'hE1_0000;
    localparam logic [23:0] LFSR_SEED = 24'h00_ACE1;

    localparam real PI = 3.14159265358979323846;

    // round((2^(out_w-1)-1) * sin((k+0.5)*pi/2^(lut_aw+1))), evaluated with a
    // Taylor series so it folds to a constant without relying on math builtins
    function automatic int quarter_sine(input int k, input int lut_aw, input int out_w);
        real x;
        real term;
        real sum;
        real amp;
        x    = (real'(k) + 0.5) * PI / real'(2 ** (lut_aw + 1));
        sum  = x;
        term = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp = real'((2 ** (out_w - 1)) - 1);
        return $rtoi(amp * sum + 0.5);
    endfunction

endpackage

// File: rtl/nco_quad_qrom.sv
// Dual-read quarter-wave sine magnitude ROM with a registered read port pair;
// contents are generated at elaboration from nco_pkg::quarter_sine.
module nco_qrom
    import nco_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LUT_AW-1:0] addr_a,
    input  logic [LUT_AW-1:0] addr_b,
    output logic [OUT_W-2:0]  data_a,
    output logic [OUT_W-2:0]  data_b
);

    localparam int DEPTH = 2 ** LUT_AW;
    localparam int MAG_W = OUT_W - 1;

    logic [MAG_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [MAG_W-1:0] ENTRY = MAG_W'(quarter_sine(k, LUT_AW, OUT_W));
        assign rom[k] = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/nco_quad.sv
// Quadrature NCO: phase accumulator, quarter-wave sine/cosine lookup, 3-stage pipeline.
// Optional phase dither is enabled by defining NCO_DITHER_EN.
module nco_quad
    import nco_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce,
    input  logic [ACC_W-1:0]        freq,
    input  logic                    freq_load,
    input  logic [ACC_W-1:0]        phs_ofs,
    input  logic                    ofs_load,
    input  logic                    sync,
    output logic signed [OUT_W-1:0] sin,
    output logic signed [OUT_W-1:0] cos,
    output logic                    valid
);

    localparam int FRAC_W = ACC_W - LUT_AW - 2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] freq_pend;
    logic [ACC_W-1:0] freq_act;
    logic [ACC_W-1:0] ofs_pend;
    logic [ACC_W-1:0] ofs_act;

    // Pending words only become active on a sample boundary, so a load that
    // coincides with ce is seen one ce later than the current sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc       <= '0;
            freq_pend <= '0;
            freq_act  <= '0;
            ofs_pend  <= '0;
            ofs_act   <= '0;
        end else begin
            if (freq_load) freq_pend <= freq;
            if (ofs_load)  ofs_pend  <= phs_ofs;
            if (ce) begin
                freq_act <= freq_pend;
                ofs_act  <= ofs_pend;
            end
            if (sync)    acc <= '0;
            else if (ce) acc <= acc + freq_act;
        end
    end

    logic [LUT_AW+1:0] phase_top;
    logic [FRAC_W-1:0] frac_unused;

`ifdef NCO_DITHER_EN
    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else if (ce)  lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
    end

    assign {phase_top, frac_unused} = acc + ofs_act + {{(ACC_W-FRAC_W){1'b0}}, lfsr[FRAC_W-1:0]};
`else
    assign {phase_top, frac_unused} = acc + ofs_act;
`endif

    logic [1:0]        quad_sin;
    logic [1:0]        quad_cos;
    logic [LUT_AW-1:0] idx;
    logic [LUT_AW-1:0] addr_sin;
    logic [LUT_AW-1:0] addr_cos;

    // Cosine is the sine a quarter turn ahead, i.e. the next quadrant with the
    // same table index; odd quadrants walk the table backwards.
    always_comb begin
        quad_sin = phase_top[LUT_AW+1 -: 2];
        quad_cos = quad_sin + 2'd1;
        idx      = phase_top[LUT_AW-1:0];
        addr_sin = quad_sin[0] ? ~idx : idx;
        addr_cos = quad_cos[0] ? ~idx : idx;
    end

    logic [LUT_AW-1:0] s1_addr_sin;
    logic [LUT_AW-1:0] s1_addr_cos;
    logic              s1_neg_sin;
    logic              s1_neg_cos;
    logic              s2_neg_sin;
    logic              s2_neg_cos;
    logic [2:0]        vld;
    logic [OUT_W-2:0]  rom_sin;
    logic [OUT_W-2:0]  rom_cos;

    nco_qrom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_qrom (
        .clk     (clk),
        .reset_n (reset_n),
        .addr_a  (s1_addr_sin),
        .addr_b  (s1_addr_cos),
        .data_a  (rom_sin),
        .data_b  (rom_cos)
    );

    logic signed [OUT_W-1:0] mag_sin;
    logic signed [OUT_W-1:0] mag_cos;

    assign mag_sin = {1'b0, rom_sin};
    assign mag_cos = {1'b0, rom_cos};

    // The datapath free-runs; only the output registers are qualified so that
    // sin/cos hold between valid samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_addr_sin <= '0;
            s1_addr_cos <= '0;
            s1_neg_sin  <= 1'b0;
            s1_neg_cos  <= 1'b0;
            s2_neg_sin  <= 1'b0;
            s2_neg_cos  <= 1'b0;
            vld         <= '0;
            sin         <= '0;
            cos         <= '0;
        end else begin
            s1_addr_sin <= addr_sin;
            s1_addr_cos <= addr_cos;
            s1_neg_sin  <= quad_sin[1];
            s1_neg_cos  <= quad_cos[1];
            s2_neg_sin  <= s1_neg_sin;
            s2_neg_cos  <= s1_neg_cos;
            vld         <= {vld[1:0], ce};
            if (vld[1]) begin
                sin <= s2_neg_sin ? -mag_sin : mag_sin;
                cos <= s2_neg_cos ? -mag_cos : mag_cos;
            end
        end
    end

    assign valid = vld[2];

endmodule
